// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared pipeline constants for fetch, decode and hazard stages
package if_stage_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_PC  = 32'd0;
  localparam word_t NOP_INSTR = 32'd0;
  localparam word_t PC_INC    = 32'd4;

  // Branch/jump targets are word-aligned by dropping the low bits, never faulted.
  function automatic word_t align_pc(input word_t addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with reset/flush-to-bubble and stall hold
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic            valid_q, valid_d;

  // Flush outranks stall: a stalled instruction on a redirected path is discarded.
  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush_i) begin
      instr_d    = NOP_INSTR;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (!stall_i) begin
      instr_d    = instr_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage; IF_PERF_CNT_EN enables fetch/flush counters
module if_stage
  import if_stage_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] pc_addr_o,
  output logic [XLEN-1:0] ifid_instr_o,
  output logic [XLEN-1:0] ifid_pc_plus4_o,
  output logic            ifid_valid_o,
  output logic [XLEN-1:0] fetch_cnt_o,
  output logic [XLEN-1:0] flush_cnt_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4 = pc_q + PC_INC;

  always_comb begin
    pc_d = pc_plus4;
    if (redirect_i) begin
      pc_d = align_pc(redirect_pc_i);
    end else if (stall_i) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_addr_o = pc_q;

  if_id_reg u_if_id_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (redirect_i),
    .stall_i    (stall_i),
    .instr_i    (instr_i),
    .pc_plus4_i (pc_plus4),
    .instr_o    (ifid_instr_o),
    .pc_plus4_o (ifid_pc_plus4_o),
    .valid_o    (ifid_valid_o)
  );

`ifdef IF_PERF_CNT_EN
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [XLEN-1:0] flush_cnt_q, flush_cnt_d;
  logic            fetch_en;

  // A valid capture happens exactly when IF/ID neither flushes nor holds.
  assign fetch_en    = !redirect_i && !stall_i;
  assign fetch_cnt_d = fetch_cnt_q + (fetch_en ? 32'd1 : 32'd0);
  assign flush_cnt_d = flush_cnt_q + (redirect_i ? 32'd1 : 32'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign fetch_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
